// File: rtl/msk_aes128_round_ctrl.sv
// rtl/msk_aes128_round_ctrl.sv - sequencer for the masked AES-128 round datapath with cleaning
module msk_aes128_round_ctrl #(
    parameter int LATENCY = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       state_en,
    output logic [1:0] state_sel,
    output logic       key_en,
    output logic       key_sel,
    output logic [7:0] rcon,
    output logic       cleaning_on,
    output logic       rnd_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_CLEAN,
        S_IDLE,
        S_ROUND,
        S_FINAL
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    state_t     state;
    logic [3:0] lat_cnt;
    logic [3:0] round_cnt;
    logic       lat_last;

    assign lat_last = (lat_cnt == LAT_LAST);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Status outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CLEAN;
            lat_cnt     <= '0;
            round_cnt   <= '0;
            rcon        <= 8'h01;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            cleaning_on <= 1'b1;
            rnd_en      <= 1'b1;
            busy        <= 1'b1;
        end else begin
            case (state)
                S_CLEAN: begin
                    if (lat_last) begin
                        state       <= S_IDLE;
                        lat_cnt     <= '0;
                        in_ready    <= 1'b1;
                        cleaning_on <= 1'b0;
                        rnd_en      <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        state     <= S_ROUND;
                        lat_cnt   <= '0;
                        round_cnt <= '0;
                        rcon      <= 8'h01;
                        in_ready  <= 1'b0;
                        rnd_en    <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_ROUND: begin
                    if (lat_last) begin
                        lat_cnt   <= '0;
                        round_cnt <= round_cnt + 4'd1;
                        rcon      <= xtime(rcon);
                        if (round_cnt == 4'd9) begin
                            state     <= S_FINAL;
                            out_valid <= 1'b1;
                            rnd_en    <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                S_FINAL: begin
                    if (out_ready) begin
                        state       <= S_CLEAN;
                        lat_cnt     <= '0;
                        rcon        <= 8'h01;
                        out_valid   <= 1'b0;
                        cleaning_on <= 1'b1;
                        rnd_en      <= 1'b1;
                    end
                end
                default: state <= S_CLEAN;
            endcase
        end
    end

    // Load on the accepting cycle; capture only on the last cycle of each pass.
    always_comb begin
        state_en  = 1'b0;
        key_en    = 1'b0;
        state_sel = 2'd0;
        key_sel   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_en = 1'b1;
                    key_en   = 1'b1;
                end
            end
            S_ROUND: begin
                if (lat_last) begin
                    state_en  = 1'b1;
                    key_en    = 1'b1;
                    key_sel   = 1'b1;
                    state_sel = (round_cnt == 4'd9) ? 2'd2 : 2'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_msk_aes128_round_ctrl.sv
// tb/tb_msk_aes128_round_ctrl.sv - self-checking bench for msk_aes128_round_ctrl (LATENCY 6 and 1)
module tb_msk_aes128_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] pt;
    logic [127:0] key;
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= a;
            a = xt(a);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] getb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(getb(s, i));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = getb(s, r + 4*((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = getb(s, 4*c); a1 = getb(s, 4*c+1); a2 = getb(s, 4*c+2); a3 = getb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s;
        logic [7:0]   rc;
        s  = p ^ k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_columns(s);
            k  = key_step(k, rc);
            rc = xt(rc);
            s  = s ^ k;
        end
        return s;
    endfunction

    function automatic logic [7:0] rc_of(input int p);
        case (p)
            0: return 8'h01; 1: return 8'h02; 2: return 8'h04; 3: return 8'h08;
            4: return 8'h10; 5: return 8'h20; 6: return 8'h40; 7: return 8'h80;
            8: return 8'h1b; 9: return 8'h36; default: return 8'h6c;
        endcase
    endfunction

    // kind 0: cycles since entering cleaning; kind 1: cycles since the block was accepted.
    function automatic int phase_of(input int kind, input int k, input int lat);
        if (kind == 0) return (k < lat) ? 0 : 1;
        return (k < 10*lat) ? 2 : 3;
    endfunction

    // {in_ready, out_valid, state_en, state_sel, key_en, key_sel, rcon, cleaning_on, rnd_en, busy}
    function automatic logic [17:0] expect_out(input int kind, input int k, input int lat, input logic iv);
        logic       cap;
        logic [1:0] sel;
        int         p;
        case (phase_of(kind, k, lat))
            0: return {1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1};
            1: return {1'b1, 1'b0, iv, 2'd0, iv, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
            2: begin
                p   = k / lat;
                cap = ((k % lat) == lat - 1);
                sel = !cap ? 2'd0 : (p == 9) ? 2'd2 : 2'd1;
                return {1'b0, 1'b0, cap, sel, cap, cap, rc_of(p), 1'b0, 1'b1, 1'b1};
            end
            default: return {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, rc_of(10), 1'b0, 1'b0, 1'b1};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 6 : 1;
        logic         in_ready, out_valid, state_en, key_en, key_sel, cleaning_on, rnd_en, busy;
        logic [1:0]   state_sel;
        logic [7:0]   rcon;
        logic [127:0] s0, s1, k0, k1, mask, exp_ct;
        int           kind = 0;
        int           k = 0;
        int           hs_cnt = 0;
        bit           mval = 1'b0;

        msk_aes128_round_ctrl #(.LATENCY(LAT)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .out_valid(out_valid), .out_ready(out_ready), .state_en(state_en),
            .state_sel(state_sel), .key_en(key_en), .key_sel(key_sel), .rcon(rcon),
            .cleaning_on(cleaning_on), .rnd_en(rnd_en), .busy(busy)
        );

        // Two-share datapath stand-in: recombine, compute a full pass, re-split with fresh masks.
        always @(posedge clk) begin
            mask <= {$urandom, $urandom, $urandom, $urandom};
            if (state_en) begin
                case (state_sel)
                    2'd0: begin s0 <= pt ^ mask; s1 <= mask; end
                    2'd1: begin s0 <= mix_columns(shift_rows(sub_bytes(s0 ^ s1 ^ k0 ^ k1))) ^ mask; s1 <= mask; end
                    2'd2: begin s0 <= shift_rows(sub_bytes(s0 ^ s1 ^ k0 ^ k1)) ^ mask; s1 <= mask; end
                    default: ;
                endcase
            end
            if (key_en) begin
                if (key_sel) k0 <= key_step(k0 ^ k1, rcon) ^ ~mask;
                else         k0 <= key ^ ~mask;
                k1 <= ~mask;
            end
        end

        always @(negedge clk) begin
            if (mval) begin
                chk($sformatf("ctrl_outputs_lat%0d", LAT),
                    {in_ready, out_valid, state_en, state_sel, key_en, key_sel, rcon, cleaning_on, rnd_en, busy},
                    expect_out(kind, k, LAT, in_valid));
                if (phase_of(kind, k, LAT) == 3 && out_ready) begin
                    chk($sformatf("ciphertext_lat%0d", LAT), s0 ^ s1 ^ k0 ^ k1, exp_ct);
                    hs_cnt <= hs_cnt + 1;
                end
            end
            if (rst) begin
                kind <= 0;
                k    <= 0;
                mval <= 1'b1;
            end else if (mval) begin
                if (phase_of(kind, k, LAT) == 1 && in_valid) begin
                    kind   <= 1;
                    k      <= 0;
                    exp_ct <= aes_ref(pt, key);
                end else if (phase_of(kind, k, LAT) == 3 && out_ready) begin
                    kind <= 0;
                    k    <= 0;
                end else if (k < 100000) begin
                    k <= k + 1;
                end
            end
        end
    end

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (g_inst[0].in_ready) acc = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic run_block(input logic [127:0] p, input logic [127:0] kk, input int hold,
                             output int lat, output logic [127:0] ct, output int ne, output int ke,
                             output int s2, output logic [79:0] rcs, output bit stable, output int gap);
        lat = 0; ct = '0; ne = 0; ke = 0; s2 = 0; rcs = '0; stable = 1'b1; gap = 0;
        @(posedge clk); #1;
        pt = p; key = kk; out_ready = (hold == 0);
        wait_accept();
        if (g_inst[0].state_en) ne++;
        if (g_inst[0].key_en) ke++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int t = 1; t <= 200 && lat == 0; t++) begin
            @(negedge clk);
            if (g_inst[0].state_en) begin
                ne++;
                if (g_inst[0].state_sel == 2'd2) s2++;
                rcs = {rcs[71:0], g_inst[0].rcon};
            end
            if (g_inst[0].key_en) ke++;
            if (g_inst[0].out_valid) begin
                lat = t;
                ct  = g_inst[0].s0 ^ g_inst[0].s1 ^ g_inst[0].k0 ^ g_inst[0].k1;
            end else begin
                @(posedge clk); #1;
            end
        end
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!g_inst[0].out_valid || g_inst[0].in_ready ||
                ((g_inst[0].s0 ^ g_inst[0].s1 ^ g_inst[0].k0 ^ g_inst[0].k1) !== ct)) stable = 1'b0;
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
        end
        for (int i = 1; i <= 50 && gap == 0; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (g_inst[0].in_ready) gap = i;
        end
    endtask

    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        int lat, ne, ke, s2, gap, n, nov, h0, h1;
        logic [127:0] ct;
        logic [79:0]  rcs;
        bit stable;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pt = '0; key = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (g_inst[0].in_ready) n = i;
        end
        chk("reset_release_ready_cycle", n, 7);

        run_block(PT_A, KEY_A, 0, lat, ct, ne, ke, s2, rcs, stable, gap);
        chk("fips_latency", lat, 61);
        chk("fips_ciphertext", ct, CT_A);
        chk("state_en_count", ne, 11);
        chk("key_en_count", ke, 11);
        chk("state_sel2_count", s2, 1);
        chk("rcon_trace", rcs, 80'h01020408102040801b36);
        chk("clean_gap", gap, 7);

        run_block(PT_B, KEY_B, 20, lat, ct, ne, ke, s2, rcs, stable, gap);
        chk("bp_latency", lat, 61);
        chk("bp_ciphertext", ct, CT_B);
        chk("bp_stable", stable, 1);
        chk("bp_clean_gap", gap, 7);

        @(posedge clk); #1;
        pt = PT_B; key = KEY_B; out_ready = 1'b1;
        wait_accept();
        nov = 0;
        for (int t = 1; t <= 30; t++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (t == 30) rst = 1'b1;
            @(negedge clk);
            if (g_inst[0].out_valid) nov++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (g_inst[0].out_valid) nov++;
            if (g_inst[0].in_ready) n = i;
        end
        chk("abort_no_out_valid", nov, 0);
        chk("abort_ready_cycle", n, 7);
        run_block(PT_A, KEY_A, 0, lat, ct, ne, ke, s2, rcs, stable, gap);
        chk("after_abort_ciphertext", ct, CT_A);

        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        h0 = g_inst[0].hs_cnt;
        h1 = g_inst[1].hs_cnt;
        for (int i = 0; i < 400 && g_inst[0].hs_cnt < h0 + 2; i++) begin
            @(negedge clk);
            @(posedge clk); #1;
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid = 1'b0;
        chk("b2b_blocks_lat6", g_inst[0].hs_cnt - h0, 2);
        chk("b2b_blocks_lat1", g_inst[1].hs_cnt - h1, 10);
        repeat (100) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
